hazard_scoreboard: RTL and testbench

Parametrised hazard-detection unit for the MIPS pipelined CPU, generalising load-use stalling to functional units of any fixed latency (ALU, load, multi-cycle MUL/DIV). It sits beside the controller and tracks a per-register countdown of cycles until each in-flight result reaches the forwarding network. It produces the ID-stage stall, a multi-cycle IF/ID flush after taken branches, and a pending-register vector.

---
 rtl/hazard_scoreboard.sv | 139 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency countdown scoreboard that
// produces the ID stall, the post-branch IF/ID flush and a pending vector.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   id_valid            ID holds a real instruction
//   id_rs_addr/_used    source rs and whether it is read
//   id_rt_addr/_used    source rt and whether it is read
//   id_wen, id_wd_addr  destination write enable and register
//   id_lat              cycles until the result is forwardable
//   id_branch_taken     ID resolved a taken branch or jump
//   freeze              global pipeline freeze
//   stall_id            hold IF/ID, bubble into EXE (combinational)
//   flush_if            clear the IF/ID register
//   pending             bit r set while register r has a result in flight
//
// Optional macro HAZARD_PERF_EN adds perf_clr, perf_stall_cycles and
// perf_flush_cycles (saturating 32-bit event counters).
module hazard_scoreboard #(
  parameter int ADDR_W      = 5,
  parameter int LAT_W       = 3,
  parameter int MAX_LAT     = 6,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [ADDR_W-1:0]    id_rs_addr,
  input  logic [ADDR_W-1:0]    id_rt_addr,
  input  logic                 id_rs_used,
  input  logic                 id_rt_used,
  input  logic                 id_wen,
  input  logic [ADDR_W-1:0]    id_wd_addr,
  input  logic [LAT_W-1:0]     id_lat,
  input  logic                 id_branch_taken,
  input  logic                 freeze,
`ifdef HAZARD_PERF_EN
  input  logic                 perf_clr,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_flush_cycles,
`endif
  output logic                 stall_id,
  output logic                 flush_if,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] ONE_L = LAT_W'(1);
  localparam logic [2:0] FDEPTH = 3'(FLUSH_DEPTH);

  logic [LAT_W-1:0] cnt     [NREG];
  logic [LAT_W-1:0] cnt_nxt [NREG];
  logic [2:0]       flush_cnt;
  logic [NREG-1:0]  pend_nxt;

  logic             accept;
  logic             hazard_rs;
  logic             hazard_rt;
  logic             issue;
  logic             wr_en;
  logic [LAT_W-1:0] lat_eff;

  assign accept = id_valid & ~freeze & (flush_cnt == 3'd0);

  assign hazard_rs = id_rs_used & (id_rs_addr != '0) &
                     (cnt[id_rs_addr] > ONE_L);
  assign hazard_rt = id_rt_used & (id_rt_addr != '0) &
                     (cnt[id_rt_addr] > ONE_L);

  // cnt==1 forwards next cycle, so only >1 stalls
  assign stall_id = accept & (hazard_rs | hazard_rt);
  assign issue    = accept & ~stall_id;
  assign wr_en    = issue & id_wen & (id_wd_addr != '0);
  assign flush_if = (flush_cnt != 3'd0);

  // zero latency still needs one cycle; overlong latency is capped
  always_comb begin
    lat_eff = id_lat;
    if (id_lat == '0)
      lat_eff = ONE_L;
    else if (id_lat > MAX_L)
      lat_eff = MAX_L;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = cnt[r];
      if (!freeze && cnt[r] != '0)
        cnt_nxt[r] = cnt[r] - ONE_L;
    end
    // younger write replaces whatever countdown is in flight
    if (wr_en)
      cnt_nxt[id_wd_addr] = lat_eff;
    cnt_nxt[0] = '0;
    pend_nxt = '0;
    for (int r = 0; r < NREG; r++)
      pend_nxt[r] = (cnt_nxt[r] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
      pending <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= cnt_nxt[r];
      pending <= pend_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flush_cnt <= 3'd0;
    else if (issue && id_branch_taken)
      flush_cnt <= FDEPTH;
    else if (flush_cnt != 3'd0 && !freeze)
      flush_cnt <= flush_cnt - 3'd1;
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_cycles <= '0;
    end else if (perf_clr) begin
      perf_stall_cycles <= '0;
      perf_flush_cycles <= '0;
    end else begin
      if (stall_id && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush_if && !freeze && perf_flush_cycles != 32'hFFFF_FFFF)
        perf_flush_cycles <= perf_flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (FLUSH_DEPTH=3).
// Each task drives one scenario and checks hand-computed results.
module tb_hazard_scoreboard;

  localparam int ADDR_W = 5;
  localparam int LAT_W  = 3;
  localparam int NREG   = 2**ADDR_W;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_wen;
  logic [ADDR_W-1:0] id_wd_addr;
  logic [LAT_W-1:0]  id_lat;
  logic              id_branch_taken;
  logic              freeze;
`ifdef HAZARD_PERF_EN
  logic              perf_clr;
  logic [31:0]       perf_stall_cycles;
  logic [31:0]       perf_flush_cycles;
`endif
  logic              stall_id;
  logic              flush_if;
  logic [NREG-1:0]   pending;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(
    .ADDR_W(ADDR_W), .LAT_W(LAT_W), .MAX_LAT(6), .FLUSH_DEPTH(3)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wen(id_wen), .id_wd_addr(id_wd_addr), .id_lat(id_lat),
    .id_branch_taken(id_branch_taken), .freeze(freeze),
`ifdef HAZARD_PERF_EN
    .perf_clr(perf_clr),
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_cycles(perf_flush_cycles),
`endif
    .stall_id(stall_id), .flush_if(flush_if), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0;
    id_rs_used = 0; id_rt_used = 0; id_wen = 0;
    id_wd_addr = 0; id_lat = 0; id_branch_taken = 0;
    freeze = 0;
`ifdef HAZARD_PERF_EN
    perf_clr = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int wd, input int lat);
    idle();
    id_valid = 1; id_wen = 1;
    id_wd_addr = ADDR_W'(wd); id_lat = LAT_W'(lat);
  endtask

  task automatic do_read_rs(input int rs);
    idle();
    id_valid = 1; id_rs_used = 1; id_rs_addr = ADDR_W'(rs);
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #12;
    total++;
    if (stall_id !== 1'b0 || flush_if !== 1'b0 || pending !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got stall=%b flush=%b pend=%h want 0 0 0",
               stall_id, flush_if, pending);
    end
    rst = 0;
    #2;
  endtask

  task automatic test_alu();
    tick();
    do_write(3, 1);
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL alu_issue_stall: got %b want 0", stall_id);
    end
    tick();
    total++;
    if (pending !== 32'h0000_0008) begin
      bad++; $display("FAIL alu_pending_set: got %h want 00000008", pending);
    end
    do_read_rs(3);
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL alu_reader_stall: got %b want 0", stall_id);
    end
    tick();
    total++;
    if (pending !== '0) begin
      bad++; $display("FAIL alu_pending_clr: got %h want 0", pending);
    end
  endtask

  task automatic test_load_use();
    int n;
    do_write(5, 2);
    tick();
    idle();
    id_valid = 1; id_rt_used = 1; id_rt_addr = 5;
    #1;
    n = 0;
    while (stall_id === 1'b1 && n < 20) begin
      tick(); n++;
    end
    total++;
    if (n != 1) begin
      bad++; $display("FAIL load_use_stall_len: got %0d want 1", n);
    end
    total++;
    if (pending !== 32'h0000_0020) begin
      bad++; $display("FAIL load_use_pend_mid: got %h want 00000020", pending);
    end
    tick();
    total++;
    if (pending !== '0) begin
      bad++; $display("FAIL load_use_pend_clr: got %h want 0", pending);
    end
  endtask

  task automatic test_mul();
    int n;
    do_write(8, 6);
    tick();
    do_read_rs(8);
    #1;
    n = 0;
    while (stall_id === 1'b1 && n < 20) begin
      total++;
      if (pending !== 32'h0000_0100) begin
        bad++; $display("FAIL mul_pend_hold: got %h want 00000100", pending);
      end
      tick(); n++;
    end
    total++;
    if (n != 5) begin
      bad++; $display("FAIL mul_stall_len: got %0d want 5", n);
    end
    tick();
    idle();
    total++;
    if (pending !== '0) begin
      bad++; $display("FAIL mul_pend_clr: got %h want 0", pending);
    end
  endtask

  task automatic test_waw();
    do_write(9, 6);
    tick();
    do_write(9, 1);
    tick();
    do_read_rs(9);
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL waw_reader_stall: got %b want 0", stall_id);
    end
    tick();
    idle();
    total++;
    if (pending !== '0) begin
      bad++; $display("FAIL waw_pend_clr: got %h want 0", pending);
    end
  endtask

  task automatic test_lat_bounds();
    int n;
    do_write(10, 0);
    tick();
    total++;
    if (pending !== 32'h0000_0400) begin
      bad++; $display("FAIL lat0_pend: got %h want 00000400", pending);
    end
    idle();
    tick();
    total++;
    if (pending !== '0) begin
      bad++; $display("FAIL lat0_clr: got %h want 0", pending);
    end
    do_write(11, 7);
    tick();
    do_read_rs(11);
    #1;
    n = 0;
    while (stall_id === 1'b1 && n < 20) begin
      tick(); n++;
    end
    total++;
    if (n != 5) begin
      bad++; $display("FAIL lat_clamp_stall_len: got %0d want 5", n);
    end
    tick();
    do_write(0, 6);
    tick();
    total++;
    if (pending !== '0) begin
      bad++; $display("FAIL r0_write_pend: got %h want 0", pending);
    end
    idle();
  endtask

  task automatic test_branch();
    int n;
    do_write(13, 6);
    id_branch_taken = 1;
    #1;
    total++;
    if (flush_if !== 1'b0) begin
      bad++; $display("FAIL br_flush_early: got %b want 0", flush_if);
    end
    tick();
    idle();
    id_valid = 1; id_rs_used = 1; id_rs_addr = 13;
    id_wen = 1; id_wd_addr = 12; id_lat = 6;
    #1;
    n = 0;
    while (flush_if === 1'b1 && n < 20) begin
      total++;
      if (stall_id !== 1'b0 || pending[12] !== 1'b0) begin
        bad++;
        $display("FAIL br_squash: got stall=%b p12=%b want 0 0",
                 stall_id, pending[12]);
      end
      tick(); n++;
    end
    total++;
    if (n != 3) begin
      bad++; $display("FAIL br_flush_len: got %0d want 3", n);
    end
    total++;
    if (stall_id !== 1'b1 || pending !== 32'h0000_2000) begin
      bad++;
      $display("FAIL br_after: got stall=%b pend=%h want 1 00002000",
               stall_id, pending);
    end
    idle();
    tick(); tick(); tick();
  endtask

  task automatic test_freeze();
    int n;
    do_write(8, 6);
    tick();
    do_read_rs(8);
    tick(); tick();
    freeze = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (stall_id !== 1'b0 || pending !== 32'h0000_0100) begin
        bad++;
        $display("FAIL frz_hold: got stall=%b pend=%h want 0 00000100",
                 stall_id, pending);
      end
      tick();
    end
    freeze = 0;
    #1;
    n = 0;
    while (stall_id === 1'b1 && n < 20) begin
      tick(); n++;
    end
    total++;
    if (n != 3) begin
      bad++; $display("FAIL frz_resume_len: got %0d want 3", n);
    end
    tick();
    idle();
    idle();
    id_valid = 1; id_branch_taken = 1;
    tick();
    idle();
    freeze = 1;
    tick(); tick();
    total++;
    if (flush_if !== 1'b1) begin
      bad++; $display("FAIL frz_flush_hold: got %b want 1", flush_if);
    end
    freeze = 0;
    n = 0;
    while (flush_if === 1'b1 && n < 20) begin
      tick(); n++;
    end
    total++;
    if (n != 3) begin
      bad++; $display("FAIL frz_flush_len: got %0d want 3", n);
    end
  endtask

  task automatic test_async_reset();
    do_write(20, 6);
    tick();
    do_read_rs(20);
    #1;
    total++;
    if (stall_id !== 1'b1) begin
      bad++; $display("FAIL ar_pre_stall: got %b want 1", stall_id);
    end
    #1;
    rst = 1;
    #1;
    total++;
    if (stall_id !== 1'b0 || flush_if !== 1'b0 || pending !== '0) begin
      bad++;
      $display("FAIL ar_clear: got stall=%b flush=%b pend=%h want 0 0 0",
               stall_id, flush_if, pending);
    end
    tick();
    #2;
    rst = 0;
    #1;
    total++;
    if (stall_id !== 1'b0 || pending !== '0) begin
      bad++;
      $display("FAIL ar_after: got stall=%b pend=%h want 0 0",
               stall_id, pending);
    end
    idle();
  endtask

  initial begin
    rst = 0;
    idle();
    test_reset();
    test_alu();
    test_load_use();
    test_mul();
    test_waw();
    test_lat_bounds();
    test_branch();
    test_freeze();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
